ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the ID/EX/MEM stages of the 16-bit WISC pipeline.
//  Detects load-use hazards that forwarding cannot resolve, and inserts ID/EX bubbles for them.
//  Flushes IF/ID and ID/EX on a taken branch or jump that is resolved in EX.
//  Freezes the whole pipe while data memory reports busy. Sits beside forward_unit and drives
//  the PC, IF/ID, ID/EX and EX/MEM stall/flush enables.
// PARAMETERS
//  LU_BUBBLES  1   load-use bubbles inserted per hazard, legal values 1..3
//  CNT_W       16  width of stall_count (STALL_CNT_EN only)
// PORTS
//  clk              in   1      system clock
//  rst_n            in   1      asynchronous reset, active low
//  IFID_Instr       in   16     instr in IF/ID; Rs=[10:8], Rt=[7:5]
//  IFID_UsesRs      in   1      IF/ID instr reads Rs
//  IFID_UsesRt      in   1      IF/ID instr reads Rt
//  IDEX_MemReadEN   in   1      ID/EX instr is a load
//  IDEX_DstRegNum   in   3      ID/EX destination register
//  IDEX_RegWriteEN  in   1      ID/EX instr writes the register file
//  EX_BranchTaken   in   1      EX resolved a taken branch, or a jump
//  mem_busy         in   1      data memory cannot accept/complete an access this cycle
//  stall_pc         out  1      hold PC
//  stall_ifid       out  1      hold IF/ID
//  bubble_idex      out  1      load NOP into ID/EX
//  flush_ifid       out  1      load NOP into IF/ID
//  stall_exmem      out  1      hold EX/MEM and MEM/WB
//  state            out  2      FSM state: RUN=0, LU=1, MWAIT=2, FLUSH=3
//  stall_count      out  CNT_W  stalled-cycle counter (STALL_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async, may occur at any time): state=RUN, lu_cnt=0, pend_flush=0, stall_count=0.
//    During reset all outputs are 0, including any operation in progress.
//  - lu_hit = IDEX_MemReadEN & IDEX_RegWriteEN & ((IFID_UsesRs & Rs==Dst) | (IFID_UsesRt & Rt==Dst)).
//  - Outputs are combinational from state and inputs. State updates on posedge clk.
//  - Input priority: mem_busy > EX_BranchTaken > lu_hit.
//  - RUN:
//      mem_busy: all five stall/flush outputs follow the MWAIT rule; pend_flush<=EX_BranchTaken;
//        next state MWAIT.
//      else EX_BranchTaken: flush_ifid=1, bubble_idex=1; next state FLUSH.
//      else lu_hit: stall_pc=1, stall_ifid=1, bubble_idex=1. If LU_BUBBLES>1, go to LU
//        with lu_cnt=LU_BUBBLES-1; otherwise stay in RUN.
//      else all outputs 0.
//  - LU: stall_pc=stall_ifid=bubble_idex=1. lu_cnt decrements each cycle; go to RUN after
//    lu_cnt reaches 1. mem_busy in LU: go to MWAIT and keep lu_cnt; resume LU after MWAIT.
//  - MWAIT: stall_pc=stall_ifid=stall_exmem=1, bubble_idex=0 (ID/EX holds).
//    EX_BranchTaken is ignored here; it is captured in pend_flush on entry.
//    When mem_busy=0: if pend_flush, apply flush outputs this cycle, clear pend_flush, go to FLUSH;
//    else if lu_cnt!=0, go to LU; else go to RUN.
//  - FLUSH: exactly 1 cycle, all outputs 0, lu_hit ignored (IF/ID holds a NOP). Next state RUN,
//    or MWAIT if mem_busy.
//  - Never assert flush_ifid and stall_ifid in the same cycle. flush wins only outside MWAIT.
//  - lu_cnt is 2 bits wide and never underflows. LU_BUBBLES outside 1..3 is a $error at elaboration.
// CONFIGURATION
//  STALL_CNT_EN defined: stall_count increments (saturating at all-ones) on every cycle with
//    stall_pc=1. It is reset by rst_n only.
//  STALL_CNT_EN undefined: stall_count port tied to 0, no counter flops.
// TESTING
//  - Reset mid-MWAIT: mem_busy=1 for 3 cycles, pull rst_n low -> all outputs 0 and state=0
//    asynchronously.
//  - Load-use: IDEX load to r3, IFID_Instr Rs=3, UsesRs=1, LU_BUBBLES=1 -> 1 cycle of
//    stall_pc/stall_ifid/bubble_idex=1, then 0.
//  - LU_BUBBLES=3, same hazard -> stall asserted 3 consecutive cycles, state 0,1,1,0.
//  - Dst=3 with RegWriteEN=0, or UsesRt=0 with Rt=3 -> no stall.
//  - EX_BranchTaken=1 and mem_busy=1 for 2 cycles -> 2 cycles of stall_exmem=1, then
//    flush_ifid=bubble_idex=1 on the first non-busy cycle, then FLUSH, then RUN.
//  - STALL_CNT_EN, 4 hazards with LU_BUBBLES=2 plus 5 busy cycles -> stall_count=13.
//    CNT_W=2 -> saturates at 3.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ID/EX/MEM sequencing: load-use bubbles, EX branch flush, memory-busy freeze.
// Optional stalled-cycle counter enabled by defining STALL_CNT_EN.
module ex_hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      IFID_Instr,
  input  logic             IFID_UsesRs,
  input  logic             IFID_UsesRt,
  input  logic             IDEX_MemReadEN,
  input  logic [2:0]       IDEX_DstRegNum,
  input  logic             IDEX_RegWriteEN,
  input  logic             EX_BranchTaken,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             stall_exmem,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU    = 2'd1,
    MWAIT = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam bit       MULTI   = (LU_BUBBLES > 1);
  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

  if (LU_BUBBLES < 1 || LU_BUBBLES > 3) begin : g_bad_lu
    $error("ex_hazard_ctrl: LU_BUBBLES must be 1..3");
  end

  state_e     state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       pend_q, pend_d;
  logic       lu_hit;
  logic       sp_c, si_c, bi_c, fi_c, se_c;
  logic       unused_ok;

  assign unused_ok = ^{IFID_Instr[15:11], IFID_Instr[4:0]};

  assign lu_hit = IDEX_MemReadEN & IDEX_RegWriteEN &
    ((IFID_UsesRs & (IFID_Instr[10:8] == IDEX_DstRegNum)) |
     (IFID_UsesRt & (IFID_Instr[7:5] == IDEX_DstRegNum)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      lu_cnt_q <= 2'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    pend_d   = pend_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MWAIT;
          pend_d  = EX_BranchTaken;
        end else if (EX_BranchTaken) begin
          state_d = FLUSH;
        end else if (lu_hit && MULTI) begin
          state_d  = LU;
          lu_cnt_d = LU_INIT;
        end
      end
      LU: begin
        if (mem_busy) begin
          state_d = MWAIT;
          pend_d  = EX_BranchTaken;
        end else begin
          lu_cnt_d = (lu_cnt_q != 2'd0) ? lu_cnt_q - 2'd1 : 2'd0;
          if (lu_cnt_q <= 2'd1) state_d = RUN;
        end
      end
      MWAIT: begin
        if (!mem_busy) begin
          if (pend_q) begin
            state_d  = FLUSH;
            pend_d   = 1'b0;
            lu_cnt_d = 2'd0;
          end else if (lu_cnt_q != 2'd0) begin
            state_d = LU;
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        pend_d  = 1'b0;
        state_d = mem_busy ? MWAIT : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A busy memory freezes every stage regardless of state.
  always_comb begin
    sp_c = 1'b0;
    si_c = 1'b0;
    bi_c = 1'b0;
    fi_c = 1'b0;
    se_c = 1'b0;
    if (mem_busy) begin
      sp_c = 1'b1;
      si_c = 1'b1;
      se_c = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (EX_BranchTaken) begin
            fi_c = 1'b1;
            bi_c = 1'b1;
          end else if (lu_hit) begin
            sp_c = 1'b1;
            si_c = 1'b1;
            bi_c = 1'b1;
          end
        end
        LU: begin
          sp_c = 1'b1;
          si_c = 1'b1;
          bi_c = 1'b1;
        end
        MWAIT: begin
          if (pend_q) begin
            fi_c = 1'b1;
            bi_c = 1'b1;
          end
        end
        FLUSH: ;
        default: ;
      endcase
    end
  end

  assign stall_pc    = rst_n & sp_c;
  assign stall_ifid  = rst_n & si_c;
  assign bubble_idex = rst_n & bi_c;
  assign flush_ifid  = rst_n & fi_c;
  assign stall_exmem = rst_n & se_c;
  assign state       = state_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_pc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl with LU_BUBBLES 1, 2 and 3 instances.
module tb_ex_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        urs, urt, mrd, rwe, br, busy;
  logic [2:0]  dst;
  logic [4:0]  o1, o2, o3, os;
  logic [1:0]  s1, s2, s3, ss;
  logic [15:0] c1, c2, c3;
  logic [1:0]  cs;
  int          checks;
  int          errors;

  ex_hazard_ctrl #(.LU_BUBBLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .IFID_Instr(instr),
    .IFID_UsesRs(urs), .IFID_UsesRt(urt),
    .IDEX_MemReadEN(mrd), .IDEX_DstRegNum(dst),
    .IDEX_RegWriteEN(rwe), .EX_BranchTaken(br),
    .mem_busy(busy), .stall_pc(o1[4]), .stall_ifid(o1[3]),
    .bubble_idex(o1[2]), .flush_ifid(o1[1]),
    .stall_exmem(o1[0]), .state(s1), .stall_count(c1)
  );

  ex_hazard_ctrl #(.LU_BUBBLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .IFID_Instr(instr),
    .IFID_UsesRs(urs), .IFID_UsesRt(urt),
    .IDEX_MemReadEN(mrd), .IDEX_DstRegNum(dst),
    .IDEX_RegWriteEN(rwe), .EX_BranchTaken(br),
    .mem_busy(busy), .stall_pc(o2[4]), .stall_ifid(o2[3]),
    .bubble_idex(o2[2]), .flush_ifid(o2[1]),
    .stall_exmem(o2[0]), .state(s2), .stall_count(c2)
  );

  ex_hazard_ctrl #(.LU_BUBBLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .IFID_Instr(instr),
    .IFID_UsesRs(urs), .IFID_UsesRt(urt),
    .IDEX_MemReadEN(mrd), .IDEX_DstRegNum(dst),
    .IDEX_RegWriteEN(rwe), .EX_BranchTaken(br),
    .mem_busy(busy), .stall_pc(o3[4]), .stall_ifid(o3[3]),
    .bubble_idex(o3[2]), .flush_ifid(o3[1]),
    .stall_exmem(o3[0]), .state(s3), .stall_count(c3)
  );

  ex_hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(2)) us (
    .clk(clk), .rst_n(rst_n), .IFID_Instr(instr),
    .IFID_UsesRs(urs), .IFID_UsesRt(urt),
    .IDEX_MemReadEN(mrd), .IDEX_DstRegNum(dst),
    .IDEX_RegWriteEN(rwe), .EX_BranchTaken(br),
    .mem_busy(busy), .stall_pc(os[4]), .stall_ifid(os[3]),
    .bubble_idex(os[2]), .flush_ifid(os[1]),
    .stall_exmem(os[0]), .state(ss), .stall_count(cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    instr = 16'h0; urs = 0; urt = 0;
    mrd = 0; rwe = 0; dst = 3'd0;
    br = 0; busy = 0;
  endtask

  task automatic hz_rs();
    instr = 16'h0300; urs = 1; urt = 0;
    mrd = 1; rwe = 1; dst = 3'd3;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr();
    #3;
    chk("rst_out", {11'd0, o1}, 16'h0);
    chk("rst_state", {14'd0, s1}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(); #1;
    chk("idle", {11'd0, o1}, 16'h0);

    cyc(); hz_rs(); #1;
    chk("lu1_hit", {11'd0, o1}, 16'h1C);
    chk("lu3_hit", {11'd0, o3}, 16'h1C);
    chk("lu1_st", {14'd0, s1}, 16'h0);
    cyc(); clr(); #1;
    chk("lu1_done", {11'd0, o1}, 16'h0);
    chk("lu3_st1", {14'd0, s3}, 16'h1);
    chk("lu3_o1", {11'd0, o3}, 16'h1C);
    cyc(); #1;
    chk("lu3_st2", {14'd0, s3}, 16'h1);
    chk("lu3_o2", {11'd0, o3}, 16'h1C);
    cyc(); #1;
    chk("lu3_st3", {14'd0, s3}, 16'h0);
    chk("lu3_o3", {11'd0, o3}, 16'h0);

    cyc();
    hz_rs(); rwe = 0; #1;
    chk("no_rwe", {11'd0, o1}, 16'h0);
    instr = 16'h0060; rwe = 1; urs = 0; urt = 0; #1;
    chk("no_urt", {11'd0, o1}, 16'h0);
    urt = 1; #1;
    chk("rt_hit", {11'd0, o1}, 16'h1C);
    clr(); #1;

    cyc(); br = 1; #1;
    chk("br_out", {11'd0, o1}, 16'h06);
    cyc(); br = 0; #1;
    chk("br_flush", {14'd0, s1}, 16'h3);
    chk("br_fl_o", {11'd0, o1}, 16'h0);
    cyc(); #1;
    chk("br_run", {14'd0, s1}, 16'h0);

    cyc(); br = 1; busy = 1; #1;
    chk("bb_o1", {11'd0, o1}, 16'h19);
    chk("bb_s1", {14'd0, s1}, 16'h0);
    cyc(); #1;
    chk("bb_o2", {11'd0, o1}, 16'h19);
    chk("bb_s2", {14'd0, s1}, 16'h2);
    cyc(); br = 0; busy = 0; #1;
    chk("bb_fl_o", {11'd0, o1}, 16'h06);
    chk("bb_fl_s", {14'd0, s1}, 16'h2);
    cyc(); #1;
    chk("bb_flush", {14'd0, s1}, 16'h3);
    chk("bb_fl0", {11'd0, o1}, 16'h0);
    cyc(); #1;
    chk("bb_run", {14'd0, s1}, 16'h0);

    cyc(); busy = 1; #1;
    chk("mw_o", {11'd0, o1}, 16'h19);
    cyc(); busy = 0; #1;
    chk("mw_exit_s", {14'd0, s1}, 16'h2);
    chk("mw_exit_o", {11'd0, o1}, 16'h0);
    cyc(); #1;
    chk("mw_run", {14'd0, s1}, 16'h0);

    cyc(); hz_rs(); #1;
    chk("lub_hit", {11'd0, o3}, 16'h1C);
    cyc(); clr(); busy = 1; #1;
    chk("lub_s", {14'd0, s3}, 16'h1);
    chk("lub_o", {11'd0, o3}, 16'h19);
    cyc(); busy = 0; #1;
    chk("lub_mw", {14'd0, s3}, 16'h2);
    cyc(); #1;
    chk("lub_res", {14'd0, s3}, 16'h1);
    chk("lub_res_o", {11'd0, o3}, 16'h1C);
    cyc(); #1;
    chk("lub_res2", {14'd0, s3}, 16'h1);
    cyc(); #1;
    chk("lub_end", {14'd0, s3}, 16'h0);

    cyc(); busy = 1;
    cyc();
    cyc(); #1;
    chk("rmw_s", {14'd0, s1}, 16'h2);
    chk("rmw_o", {11'd0, o1}, 16'h19);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_o", {11'd0, o1}, 16'h0);
    chk("rmw_rst_s", {14'd0, s1}, 16'h0);
    chk("rmw_rst_o3", {11'd0, o3}, 16'h0);
    busy = 0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef STALL_CNT_EN
    #1;
    chk("cnt_rst", c2, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(); hz_rs();
      cyc(); clr();
    end
    cyc(); busy = 1;
    repeat (4) cyc();
    cyc(); busy = 0;
    cyc(); #1;
    chk("cnt_13", c2, 16'd13);
    chk("cnt_sat", {14'd0, cs}, 16'd3);
`else
    cyc(); #1;
    chk("cnt_tied", c2, 16'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
